// File: rtl/ball_roll.sv
// ---------------------------------------------------------------------------
// ball_roll -- bowling lane ball travel controller.
//
// A rising edge on throw while idle (with a legal power level 1..4) launches
// the ball.  It then advances one lane position every
// STEP_CYCLES*(5-power) clocks.  When the last position's period expires the
// block reports completion and the number of pins knocked, then waits for
// next_frame before returning to idle.
//
// Optional feature macro: BALL_ROLL_GUTTER_EN
//   When defined, an extra 2-bit aim input is latched at release.  An aim of
//   2'b00 or 2'b11 is a gutter ball, which scores zero pins.  Roll timing is
//   the same either way.
//
// Parameters
//   STEP_CYCLES : clock cycles per lane step at power 4
//   LANE_LEN    : number of lane positions (2..16)
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   throw      in   release request; its rising edge acts
//   pow_lvl    in   [2:0] power level, legal 1..4
//   next_frame in   acknowledge; returns the block from DONE to IDLE
//   aim        in   [1:0] aim, only with BALL_ROLL_GUTTER_EN
//   ball_pos   out  [3:0] current lane position
//   rolling    out  high while the ball travels
//   done       out  one-cycle pulse on roll completion
//   pins_down  out  [3:0] pins knocked, valid in DONE
//   throw_pow  out  [2:0] power latched at release
// ---------------------------------------------------------------------------
module ball_roll #(
   parameter int unsigned STEP_CYCLES = 32'd25000000,
   parameter int unsigned LANE_LEN    = 32'd12
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       throw,
   input  logic [2:0] pow_lvl,
   input  logic       next_frame,
`ifdef BALL_ROLL_GUTTER_EN
   input  logic [1:0] aim,
`endif
   output logic [3:0] ball_pos,
   output logic       rolling,
   output logic       done,
   output logic [3:0] pins_down,
   output logic [2:0] throw_pow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROLL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] STEP_32  = 32'(STEP_CYCLES);
   localparam logic [3:0]  LAST_POS = 4'(LANE_LEN - 32'd1);

   // Pin count awarded for each legal power level; anything else scores zero.
   function automatic logic [3:0] pins_for_pow(input logic [2:0] pow);
      logic [3:0] pins;
      case (pow)
         3'd1:    pins = 4'd2;
         3'd2:    pins = 4'd5;
         3'd3:    pins = 4'd8;
         3'd4:    pins = 4'd10;
         default: pins = 4'd0;
      endcase
      return pins;
   endfunction

   state_t      state_q,      state_d;
   logic [3:0]  ball_pos_q,   ball_pos_d;
   logic        rolling_q,    rolling_d;
   logic        done_q,       done_d;
   logic [3:0]  pins_down_q,  pins_down_d;
   logic [2:0]  throw_pow_q,  throw_pow_d;
   logic [31:0] step_cnt_q,   step_cnt_d;
   logic        throw_prev_q, throw_prev_d;
`ifdef BALL_ROLL_GUTTER_EN
   logic [1:0]  aim_q,        aim_d;
   logic        gutter_s;
`endif

   logic        throw_edge_s;
   logic        pow_valid_s;
   logic [31:0] period_s;
   logic        period_end_s;
   logic [3:0]  score_s;

   assign throw_edge_s = throw & ~throw_prev_q;
   assign pow_valid_s  = (pow_lvl >= 3'd1) && (pow_lvl <= 3'd4);
   // Period is derived from the latched power, so pow_lvl changes mid-roll
   // cannot disturb timing.
   assign period_s     = STEP_32 * (32'd5 - {29'd0, throw_pow_q});
   assign period_end_s = (step_cnt_q == (period_s - 32'd1));

`ifdef BALL_ROLL_GUTTER_EN
   assign gutter_s = (aim_q == 2'b00) || (aim_q == 2'b11);
   assign score_s  = gutter_s ? 4'd0 : pins_for_pow(throw_pow_q);
`else
   assign score_s  = pins_for_pow(throw_pow_q);
`endif

   // Next-state and next-output computation for the roll controller.
   always_comb begin
      state_d      = state_q;
      ball_pos_d   = ball_pos_q;
      rolling_d    = rolling_q;
      done_d       = 1'b0;
      pins_down_d  = pins_down_q;
      throw_pow_d  = throw_pow_q;
      step_cnt_d   = step_cnt_q;
      throw_prev_d = throw;
`ifdef BALL_ROLL_GUTTER_EN
      aim_d        = aim_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (throw_edge_s && pow_valid_s) begin
               state_d     = ST_ROLL;
               throw_pow_d = pow_lvl;
               ball_pos_d  = 4'd0;
               rolling_d   = 1'b1;
               step_cnt_d  = 32'd0;
`ifdef BALL_ROLL_GUTTER_EN
               aim_d       = aim;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ROLL: begin
            if (period_end_s) begin
               step_cnt_d = 32'd0;
               if (ball_pos_q == LAST_POS) begin
                  // Last position's period has elapsed: ball reaches the pins.
                  state_d     = ST_DONE;
                  rolling_d   = 1'b0;
                  done_d      = 1'b1;
                  pins_down_d = score_s;
               end else begin
                  ball_pos_d = ball_pos_q + 4'd1;
               end
            end else begin
               step_cnt_d = step_cnt_q + 32'd1;
            end
         end

         ST_DONE: begin
            // next_frame takes priority over any throw edge in this state;
            // the throw sample register stays current, so a coincident edge
            // is not seen again once idle.
            if (next_frame) begin
               state_d     = ST_IDLE;
               ball_pos_d  = 4'd0;
               pins_down_d = 4'd0;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            ball_pos_d  = 4'd0;
            rolling_d   = 1'b0;
            pins_down_d = 4'd0;
            step_cnt_d  = 32'd0;
         end
      endcase
   end

   // State and registered-output flops; throw sample resets high so a throw
   // held through reset release does not launch.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         ball_pos_q   <= 4'd0;
         rolling_q    <= 1'b0;
         done_q       <= 1'b0;
         pins_down_q  <= 4'd0;
         throw_pow_q  <= 3'd0;
         step_cnt_q   <= 32'd0;
         throw_prev_q <= 1'b1;
`ifdef BALL_ROLL_GUTTER_EN
         aim_q        <= 2'b00;
`endif
      end else begin
         state_q      <= state_d;
         ball_pos_q   <= ball_pos_d;
         rolling_q    <= rolling_d;
         done_q       <= done_d;
         pins_down_q  <= pins_down_d;
         throw_pow_q  <= throw_pow_d;
         step_cnt_q   <= step_cnt_d;
         throw_prev_q <= throw_prev_d;
`ifdef BALL_ROLL_GUTTER_EN
         aim_q        <= aim_d;
`endif
      end
   end

   assign ball_pos  = ball_pos_q;
   assign rolling   = rolling_q;
   assign done      = done_q;
   assign pins_down = pins_down_q;
   assign throw_pow = throw_pow_q;

endmodule

// File: tb/tb_ball_roll.sv
// ---------------------------------------------------------------------------
// tb_ball_roll -- directed, scoreboard-based bench for ball_roll with
// STEP_CYCLES=2 and LANE_LEN=4.  Each step pushes the expected output record
// into a queue and pops it against the DUT outputs #1 after the clock edge
// (or between edges for the asynchronous reset checks).
// ---------------------------------------------------------------------------
module tb_ball_roll;

   localparam int STEP = 2;
   localparam int LANE = 4;

   logic       CLOCK_50;
   logic       reset;
   logic       throw;
   logic [2:0] pow_lvl;
   logic       next_frame;
   logic [1:0] aim;
   logic [3:0] ball_pos;
   logic       rolling;
   logic       done;
   logic [3:0] pins_down;
   logic [2:0] throw_pow;

   typedef struct packed {
      logic [3:0] pos;
      logic       rol;
      logic       dn;
      logic [3:0] pins;
      logic [2:0] pow;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   ball_roll #(.STEP_CYCLES(STEP), .LANE_LEN(LANE)) dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .throw     (throw),
      .pow_lvl   (pow_lvl),
      .next_frame(next_frame),
`ifdef BALL_ROLL_GUTTER_EN
      .aim       (aim),
`endif
      .ball_pos  (ball_pos),
      .rolling   (rolling),
      .done      (done),
      .pins_down (pins_down),
      .throw_pow (throw_pow)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic push_exp(input int pos, input bit rol, input bit dn,
                           input int pins, input int pow);
      exp_t e;
      e.pos  = 4'(pos);
      e.rol  = rol;
      e.dn   = dn;
      e.pins = 4'(pins);
      e.pow  = 3'(pow);
      sb_q.push_back(e);
   endtask

   task automatic check(input string tag);
      exp_t e;
      exp_t obs;
      obs = {ball_pos, rolling, done, pins_down, throw_pow};
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty observed=%h", tag, obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed pos=%0d rol=%0b done=%0b pins=%0d pow=%0d expected pos=%0d rol=%0b done=%0b pins=%0d pow=%0d",
                   tag, obs.pos, obs.rol, obs.dn, obs.pins, obs.pow,
                   e.pos, e.rol, e.dn, e.pins, e.pow);
         end
      end
   endtask

   task automatic expect_now(input int pos, input bit rol, input bit dn,
                             input int pins, input int pow, input string tag);
      push_exp(pos, rol, dn, pins, pow);
      check(tag);
   endtask

   // Launch from IDLE (throw must already be low) and follow the full roll
   // up to the done pulse.  Throw edges and next_frame are poked mid-roll.
   task automatic do_roll(input int p, input int pins_e, input bit mid_change);
      int per;
      per = STEP * (5 - p);
      pow_lvl = 3'(p);
      throw   = 1'b1;
      tick();
      expect_now(0, 1'b1, 1'b0, 0, p, $sformatf("launch_p%0d", p));
      throw = 1'b0;
      for (int k = 1; k <= LANE * per; k++) begin
         if (k == 3) begin
            throw      = 1'b1;
            next_frame = 1'b1;
         end else if (k == 4) begin
            throw      = 1'b0;
            next_frame = 1'b0;
         end
         if (mid_change && k == 5) pow_lvl = 3'd4;
         tick();
         if (k < LANE * per)
            expect_now(k / per, 1'b1, 1'b0, 0, p, $sformatf("roll_p%0d_k%0d", p, k));
         else
            expect_now(LANE - 1, 1'b0, 1'b1, pins_e, p, $sformatf("done_p%0d", p));
      end
   endtask

   initial begin
      reset      = 1'b1;
      throw      = 1'b0;
      pow_lvl    = 3'd0;
      next_frame = 1'b0;
      aim        = 2'b01;

      #2 reset = 1'b0;
      #1 expect_now(0, 1'b0, 1'b0, 0, 0, "reset_async");
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "reset_held");
      reset = 1'b1;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "idle_after_reset");

      next_frame = 1'b1;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "idle_next_frame");
      next_frame = 1'b0;

      pow_lvl = 3'd0; throw = 1'b1;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "pow0_ignored");
      throw = 1'b0;
      tick();
      pow_lvl = 3'd5; throw = 1'b1;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "pow5_ignored");
      throw = 1'b0;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "idle_quiet");

      do_roll(4, 10, 1'b0);
      tick();
      expect_now(3, 1'b0, 1'b0, 10, 4, "done_pulse_drops");
      throw = 1'b1;
      tick();
      expect_now(3, 1'b0, 1'b0, 10, 4, "done_throw_ignored");
      throw = 1'b0; next_frame = 1'b1;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 4, "next_frame_idle");
      next_frame = 1'b0;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 4, "idle_holds_pow");

      do_roll(1, 2, 1'b1);
      next_frame = 1'b1; throw = 1'b1;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 1, "coincide_idle");
      next_frame = 1'b0;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 1, "coincide_no_relaunch");
      throw = 1'b0;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 1, "idle_before_relaunch");

      do_roll(2, 5, 1'b0);
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      expect_now(0, 1'b0, 1'b0, 0, 2, "exit_p2");
      do_roll(3, 8, 1'b0);
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      expect_now(0, 1'b0, 1'b0, 0, 3, "exit_p3");

      // Reset in the middle of a roll, with throw held across release.
      pow_lvl = 3'd4; throw = 1'b1;
      tick();
      expect_now(0, 1'b1, 1'b0, 0, 4, "launch_pre_reset");
      throw = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         expect_now(k / 2, 1'b1, 1'b0, 0, 4, $sformatf("pre_reset_k%0d", k));
      end
      #2 reset = 1'b0;
      #1 expect_now(0, 1'b0, 1'b0, 0, 0, "reset_midroll_async");
      throw = 1'b1;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "reset_midroll_held");
      reset = 1'b1;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "throw_held_no_launch_1");
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "throw_held_no_launch_2");
      throw = 1'b0;
      tick();
      expect_now(0, 1'b0, 1'b0, 0, 0, "throw_dropped");
      do_roll(4, 10, 1'b0);
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      expect_now(0, 1'b0, 1'b0, 0, 4, "exit_after_reset_roll");

`ifdef BALL_ROLL_GUTTER_EN
      aim = 2'b11;
      do_roll(4, 0, 1'b0);
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      expect_now(0, 1'b0, 1'b0, 0, 4, "exit_gutter");
      aim = 2'b01;
      do_roll(4, 10, 1'b0);
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      expect_now(0, 1'b0, 1'b0, 0, 4, "exit_aimed");
`endif

      if (sb_q.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
